hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// ID-stage hazard control: load-use stall, flow-change squash,
// registered bypass selects and halt drain tracking.
module hazard_ctrl #(
  parameter int NUM_RP   = 2,
  parameter int REG_AW   = 4,
  parameter int DEPTH    = 2,
  parameter int LD_STAGE = 1,
  parameter int FLUSH_N  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [NUM_RP-1:0]        id_re,
  input  logic [NUM_RP*REG_AW-1:0] id_raddr,
  input  logic                     id_we,
  input  logic [REG_AW-1:0]        id_waddr,
  input  logic                     id_ld,
  input  logic                     id_hlt,
  input  logic                     ex_flow_change,
  input  logic                     ex_we_kill,
  output logic                     stall_id,
  output logic                     squash,
  output logic [NUM_RP*DEPTH-1:0]  byp_sel,
  output logic                     hlt_wb
);

  localparam int CW = (FLUSH_N > 1) ? $clog2(FLUSH_N) : 1;
  localparam logic [CW-1:0] CNT_LD = CW'(FLUSH_N - 1);

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] waddr;
    logic              ld;
  } wr_t;

  wr_t                     r_wr  [DEPTH];
  wr_t                     w_nxt [DEPTH];
  logic [CW-1:0]           r_cnt;
  logic                    r_hlt_seen;
  logic [DEPTH-1:0]        r_hlt_pipe;
  logic [NUM_RP*DEPTH-1:0] r_byp;
  logic [NUM_RP*DEPTH-1:0] w_byp;
  logic                    w_flush;
  logic                    w_lu;
  logic                    w_stall;
  logic                    w_squash;

  // Gating with rst_n keeps outputs quiet while reset is held.
  assign w_flush  = rst_n & (ex_flow_change | (r_cnt != '0));
  assign w_stall  = rst_n & ((w_lu & ~w_flush) | r_hlt_seen);
  assign w_squash = rst_n & (w_flush | w_lu | r_hlt_seen);

  assign stall_id = w_stall;
  assign squash   = w_squash;
  assign byp_sel  = r_byp;
  assign hlt_wb   = r_hlt_pipe[DEPTH-1];

  always_comb begin
    w_lu = 1'b0;
    for (int p = 0; p < NUM_RP; p++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (k < LD_STAGE && id_re[p] &&
            id_raddr[p*REG_AW +: REG_AW] != '0 &&
            r_wr[k].we && r_wr[k].ld &&
            r_wr[k].waddr == id_raddr[p*REG_AW +: REG_AW])
          w_lu = 1'b1;
      end
    end
  end

  // Scan from the oldest stage so the youngest match wins.
  always_comb begin
    w_byp = '0;
    for (int p = 0; p < NUM_RP; p++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (id_re[p] &&
            id_raddr[p*REG_AW +: REG_AW] != '0 &&
            r_wr[k].we &&
            r_wr[k].waddr == id_raddr[p*REG_AW +: REG_AW]) begin
          w_byp[p*DEPTH +: DEPTH] = '0;
          w_byp[p*DEPTH + k]      = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_nxt[0].we    = id_we & id_valid & ~w_squash;
    w_nxt[0].ld    = id_ld & id_valid & ~w_squash;
    w_nxt[0].waddr = id_waddr;
    for (int k = 1; k < DEPTH; k++) begin
      w_nxt[k] = r_wr[k-1];
      if (k == 1)
        w_nxt[k].we = r_wr[k-1].we & ~ex_we_kill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++)
        r_wr[k] <= '0;
      r_byp <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++)
        r_wr[k] <= w_nxt[k];
      r_byp <= w_byp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (ex_flow_change) begin
      r_cnt <= CNT_LD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hlt_seen <= 1'b0;
      r_hlt_pipe <= '0;
    end else begin
      if (id_valid & id_hlt & ~w_flush)
        r_hlt_seen <= 1'b1;
      r_hlt_pipe[0] <= r_hlt_seen;
      for (int k = 1; k < DEPTH; k++)
        r_hlt_pipe[k] <= r_hlt_pipe[k-1];
    end
  end

endmodule
